// File: rtl/urisc_pkg.sv
// Shared uRISC types and constants for the memory stage.
package urisc_pkg;

  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned REG_IDX_W        = 3;
  localparam int unsigned TMO_W            = 16;
  localparam int unsigned DMEM_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_WORD = 2'b01,
    ST_UPD  = 2'b10
  } store_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
interface memory_access_if
  import urisc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/memory_access.sv
// uRISC memory stage: accepts the ixmem bundle, runs loads/stores over the dmem
// handshake with a timeout, and produces the single-pulse memwb writeback.
module memory_access
  import urisc_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned MEM_TIMEOUT = DMEM_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    dest_reg_value_ixmem_p1,
  input  logic [REG_IDX_W-1:0] dest_reg_index_ixmem_p1,
  input  logic                 dest_reg_write_valid_ixmem_p1,
  input  logic [DATA_W-1:0]    mem_addr_ixmem_p1,
  input  logic                 ldst_valid_ixmem_p1,
  input  logic [1:0]           store_valid_ixmem_p1,
  input  logic [DATA_W-1:0]    mem_data_in_ixmem_p1,
  output logic                 stall_memix_p1,
  memory_access_if.master      dmem,
  output logic [DATA_W-1:0]    wb_reg_value_memwb_p1,
  output logic [REG_IDX_W-1:0] wb_reg_index_memwb_p1,
  output logic                 wb_reg_write_valid_memwb_p1,
  output logic                 mem_err_memwb_p1
);

  mem_state_e           state_q, state_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  store_type_e          act_st_q, act_st_d;
  logic [REG_IDX_W-1:0] act_idx_q, act_idx_d;
  logic                 act_wv_q, act_wv_d;
  logic                 req_q, req_d, we_q, we_d;
  logic [DATA_W-1:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic [DATA_W-1:0]    wb_val_d;
  logic [REG_IDX_W-1:0] wb_idx_d;
  logic                 wb_vld_d, err_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [DATA_W-1:0]    pend_val_q, pend_val_d;
  logic [REG_IDX_W-1:0] pend_idx_q, pend_idx_d;

  logic                 accept, done, timeout, new_ldst_ok, new_misal, new_alu_wb;
  logic                 done_wb_vld, first_vld;
  logic [DATA_W-1:0]    done_val, first_val;
  logic [REG_IDX_W-1:0] first_idx;

  assign stall_memix_p1   = (state_q == REQ) & ~dmem.dmem_ack;
  assign dmem.dmem_req    = req_q;
  assign dmem.dmem_we     = we_q;
  assign dmem.dmem_addr   = addr_q;
  assign dmem.dmem_wdata  = wdata_q;

  assign accept      = ~stall_memix_p1;
  assign new_ldst_ok = ldst_valid_ixmem_p1 & ~mem_addr_ixmem_p1[0];
  assign new_misal   = ldst_valid_ixmem_p1 & mem_addr_ixmem_p1[0];
  assign new_alu_wb  = ~ldst_valid_ixmem_p1 & dest_reg_write_valid_ixmem_p1;
  assign done        = (state_q == REQ) & dmem.dmem_ack;
  assign timeout     = (state_q == REQ) & ~dmem.dmem_ack &
                       (tmo_cnt_q == TMO_W'(MEM_TIMEOUT - 1));
  assign done_wb_vld = done & ((act_st_q == ST_LOAD) ? act_wv_q : (act_st_q == ST_UPD));
  assign done_val    = (act_st_q == ST_LOAD) ? dmem.dmem_rdata : addr_q;

  // A completing op (or a parked ALU result) owns the wb slot; an ALU result
  // accepted in the same cycle is parked and emitted one cycle later.
  assign first_vld = pend_vld_q | done_wb_vld;
  assign first_val = pend_vld_q ? pend_val_q : done_val;
  assign first_idx = pend_vld_q ? pend_idx_q : act_idx_q;

  // Next-state, request and writeback decode
  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    act_st_d   = act_st_q;
    act_idx_d  = act_idx_q;
    act_wv_d   = act_wv_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_vld_d   = 1'b0;
    wb_val_d   = wb_reg_value_memwb_p1;
    wb_idx_d   = wb_reg_index_memwb_p1;
    err_d      = mem_err_memwb_p1;
    pend_vld_d = 1'b0;
    pend_val_d = pend_val_q;
    pend_idx_d = pend_idx_q;

    if (state_q == REQ) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    if (done || timeout) begin
      state_d = IDLE;
      req_d   = 1'b0;
    end
    if (timeout) err_d = 1'b1;

    if (accept && new_ldst_ok) begin
      state_d   = REQ;
      tmo_cnt_d = '0;
      req_d     = 1'b1;
      we_d      = (store_valid_ixmem_p1 != ST_LOAD);
      addr_d    = mem_addr_ixmem_p1;
      wdata_d   = mem_data_in_ixmem_p1;
      act_st_d  = store_type_e'(store_valid_ixmem_p1);
      act_idx_d = dest_reg_index_ixmem_p1;
      act_wv_d  = dest_reg_write_valid_ixmem_p1;
    end
    if (accept && new_misal) err_d = 1'b1;

    if (first_vld) begin
      wb_vld_d   = 1'b1;
      wb_val_d   = first_val;
      wb_idx_d   = first_idx;
      pend_vld_d = accept & new_alu_wb;
      pend_val_d = dest_reg_value_ixmem_p1;
      pend_idx_d = dest_reg_index_ixmem_p1;
    end else if (accept && new_alu_wb) begin
      wb_vld_d = 1'b1;
      wb_val_d = dest_reg_value_ixmem_p1;
      wb_idx_d = dest_reg_index_ixmem_p1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q                     <= IDLE;
      tmo_cnt_q                   <= '0;
      act_st_q                    <= ST_LOAD;
      act_idx_q                   <= '0;
      act_wv_q                    <= 1'b0;
      req_q                       <= 1'b0;
      we_q                        <= 1'b0;
      addr_q                      <= '0;
      wdata_q                     <= '0;
      wb_reg_value_memwb_p1       <= '0;
      wb_reg_index_memwb_p1       <= '0;
      wb_reg_write_valid_memwb_p1 <= 1'b0;
      mem_err_memwb_p1            <= 1'b0;
      pend_vld_q                  <= 1'b0;
      pend_val_q                  <= '0;
      pend_idx_q                  <= '0;
    end else begin
      state_q                     <= state_d;
      tmo_cnt_q                   <= tmo_cnt_d;
      act_st_q                    <= act_st_d;
      act_idx_q                   <= act_idx_d;
      act_wv_q                    <= act_wv_d;
      req_q                       <= req_d;
      we_q                        <= we_d;
      addr_q                      <= addr_d;
      wdata_q                     <= wdata_d;
      wb_reg_value_memwb_p1       <= wb_val_d;
      wb_reg_index_memwb_p1       <= wb_idx_d;
      wb_reg_write_valid_memwb_p1 <= wb_vld_d;
      mem_err_memwb_p1            <= err_d;
      pend_vld_q                  <= pend_vld_d;
      pend_val_q                  <= pend_val_d;
      pend_idx_q                  <= pend_idx_d;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: stimulus pushes expected dmem requests and
// writebacks; a memory responder and a writeback monitor pop and compare.
module tb_memory_access;
  import urisc_pkg::*;

  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] val, addr, wdata;
  logic [2:0]    idx;
  logic          wv, ldst;
  logic [1:0]    st;
  logic          stall, wb_v, err;
  logic [DW-1:0] wb_val;
  logic [2:0]    wb_idx;

  memory_access_if #(.DATA_W(DW)) dm ();

  memory_access #(.DATA_W(DW), .MEM_TIMEOUT(TMO)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .dest_reg_value_ixmem_p1       (val),
    .dest_reg_index_ixmem_p1       (idx),
    .dest_reg_write_valid_ixmem_p1 (wv),
    .mem_addr_ixmem_p1             (addr),
    .ldst_valid_ixmem_p1           (ldst),
    .store_valid_ixmem_p1          (st),
    .mem_data_in_ixmem_p1          (wdata),
    .stall_memix_p1                (stall),
    .dmem                          (dm),
    .wb_reg_value_memwb_p1         (wb_val),
    .wb_reg_index_memwb_p1         (wb_idx),
    .wb_reg_write_valid_memwb_p1   (wb_v),
    .mem_err_memwb_p1              (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [DW-1:0] value; logic [2:0] index; int due; } wb_exp_t;
  typedef struct { logic we; logic [DW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] rdata; int delay; } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  wb_exp_t  wb_e;
  req_exp_t cur;
  int       age = 0;
  logic     late_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Writeback monitor
  always @(negedge clk) begin
    if (wb_v) begin
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: got value %0h idx %0d expected no writeback (cycle %0d)", wb_val, wb_idx, cyc);
      end else begin
        wb_e = wb_q.pop_front();
        chk("wb_value", 32'(wb_val), 32'(wb_e.value));
        chk("wb_index", 32'(wb_idx), 32'(wb_e.index));
        chk("wb_cycle", 32'(cyc), 32'(wb_e.due));
      end
    end
  end

  // Data-memory responder: checks each request, holds it stable, acks after its delay
  initial begin
    dm.dmem_ack   = 1'b0;
    dm.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dm.dmem_ack = 1'b0;
      if (rst && dm.dmem_req) begin
        if (age == 0) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: got addr %0h we %0b expected no request (cycle %0d)", dm.dmem_addr, dm.dmem_we, cyc);
            cur = '{we: dm.dmem_we, addr: dm.dmem_addr, wdata: dm.dmem_wdata, rdata: '0, delay: 1000};
          end else begin
            cur = req_q.pop_front();
          end
        end
        chk("req_we", 32'(dm.dmem_we), 32'(cur.we));
        chk("req_addr", 32'(dm.dmem_addr), 32'(cur.addr));
        if (cur.we) chk("req_wdata", 32'(dm.dmem_wdata), 32'(cur.wdata));
        if (age == cur.delay) begin
          dm.dmem_ack   = 1'b1;
          dm.dmem_rdata = cur.rdata;
          age = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
        if (late_ack) dm.dmem_ack = 1'b1;
      end
    end
  end

  task automatic drive_idle();
    val = '0; idx = '0; wv = 1'b0; addr = '0; ldst = 1'b0; st = 2'b00; wdata = '0;
  endtask

  // Present one bundle at posedge+1, hold it until accepted; acc = accepting edge index
  task automatic issue(input logic is_ldst, input logic [1:0] stype, input logic [DW-1:0] v,
                       input logic [DW-1:0] a, input logic [DW-1:0] d, input logic [2:0] i,
                       input logic w, output int acc);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    ldst = is_ldst; st = stype; val = v; addr = a; wdata = d; idx = i; wv = w;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (!stall) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: stall stayed 1 for 50 cycles, expected release");
    end
    @(posedge clk); #1;
    acc = cyc;
    drive_idle();
  endtask

  task automatic alu(input logic [DW-1:0] v, input logic [2:0] i, input logic w);
    int acc;
    issue(1'b0, 2'b00, v, 16'h0000, 16'h0000, i, w, acc);
    if (w) wb_q.push_back('{value: v, index: i, due: acc});
  endtask

  task automatic ld(input logic [DW-1:0] a, input logic [2:0] i, input logic w,
                    input logic [DW-1:0] rd, input int delay);
    int acc;
    req_q.push_back('{we: 1'b0, addr: a, wdata: '0, rdata: rd, delay: delay});
    issue(1'b1, 2'b00, 16'h0000, a, 16'h0000, i, w, acc);
    if (w && delay < 100) wb_q.push_back('{value: rd, index: i, due: acc + delay + 1});
  endtask

  task automatic stw(input logic [1:0] stype, input logic [DW-1:0] a, input logic [DW-1:0] d,
                     input logic [2:0] i, input logic w, input int delay);
    int acc;
    req_q.push_back('{we: 1'b1, addr: a, wdata: d, rdata: '0, delay: delay});
    issue(1'b1, stype, 16'h0000, a, d, i, w, acc);
    if (stype == 2'b10) wb_q.push_back('{value: a, index: i, due: acc + delay + 1});
  endtask

  task automatic count_hi(input int n, input int sel, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      if ((sel == 0) ? stall : dm.dmem_req) cnt++;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int acc;
    drive_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_wb_valid", 32'(wb_v), 32'd0);
    chk("rst_wb_value", 32'(wb_val), 32'd0);
    chk("rst_wb_index", 32'(wb_idx), 32'd0);
    chk("rst_dmem_req", 32'(dm.dmem_req), 32'd0);
    chk("rst_mem_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b1;

    // ALU op: latency-1 writeback, no memory request
    alu(16'h1234, 3'd3, 1'b1);
    wait_cycles(3);
    chk("alu_no_req", 32'(dm.dmem_req), 32'd0);
    alu(16'h0F0F, 3'd4, 1'b0);
    wait_cycles(2);

    // Load with ack 3 cycles after req
    ld(16'h0040, 3'd5, 1'b1, 16'hBEEF, 3);
    count_hi(6, 0, cnt);
    chk("ld_stall_cycles", 32'(cnt), 32'd3);

    // ST, STU and reserved store type
    stw(2'b01, 16'h0010, 16'h00AA, 3'd2, 1'b1, 1);
    wait_cycles(4);
    stw(2'b10, 16'h0010, 16'h00AA, 3'd6, 1'b0, 1);
    wait_cycles(4);
    stw(2'b11, 16'h0020, 16'h0055, 3'd4, 1'b1, 0);
    wait_cycles(3);

    // Misaligned load: error, no request, no stall
    chk("mis_err_before", 32'(err), 32'd0);
    issue(1'b1, 2'b00, 16'h0000, 16'h0041, 16'h0000, 3'd1, 1'b1, acc);
    @(negedge clk); #1;
    chk("mis_err_after", 32'(err), 32'd1);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_no_req", 32'(dm.dmem_req), 32'd0);
    wait_cycles(2);

    // Reset clears the sticky error
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("rst2_err", 32'(err), 32'd0);
    rst = 1'b1;

    // Timeout: request held 4 cycles, then abort with error; late ack ignored
    ld(16'h0080, 3'd7, 1'b1, 16'hDEAD, 1000);
    count_hi(6, 1, cnt);
    chk("tmo_req_cycles", 32'(cnt), 32'd4);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_stall", 32'(stall), 32'd0);
    @(posedge clk); #1; late_ack = 1'b1;
    @(posedge clk); #1; late_ack = 1'b0;
    @(negedge clk); #1;
    chk("late_ack_req", 32'(dm.dmem_req), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    alu(16'h5A5A, 3'd1, 1'b1);
    wait_cycles(2);

    // Reset in the middle of a request drops req and stall at once
    ld(16'h0200, 3'd3, 1'b1, 16'h7777, 1000);
    @(negedge clk); #1;
    chk("mid_req_high", 32'(dm.dmem_req), 32'd1);
    rst = 1'b0; #1;
    chk("mid_rst_req", 32'(dm.dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(posedge clk); @(negedge clk); rst = 1'b1;

    // Back-to-back loads
    ld(16'h0100, 3'd1, 1'b1, 16'h1111, 2);
    ld(16'h0102, 3'd2, 1'b1, 16'h2222, 2);
    wait_cycles(8);

    chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    chk("req_queue_empty", 32'(req_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $fatal(1);
  end

endmodule
